// File: rtl/trace_capture_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trace_capture_ctrl_pkg
// Description : Shared state encoding and default frame geometry for the
//               trace capture controller and the pixel-status renderer.
// Revision    : 1.0 - initial release
// ============================================================================
package trace_capture_ctrl_pkg;

    localparam int c_DEFAULT_DATA_SIZE = 256;
    localparam int c_DEFAULT_CHANNELS  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_PENDING = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/trace_capture_ctrl_sample_strobe_gen.sv
`default_nettype none
// ============================================================================
// Module      : sample_strobe_gen
// Description : Sample-rate divider; one strobe every sample_div+1 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_strobe_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic [DIV_WIDTH-1:0] sample_div,
    output logic                 strobe
);

    logic [DIV_WIDTH-1:0] count_q;
    logic [DIV_WIDTH-1:0] count_d;

    // >= rather than == so a divisor lowered below the running count wraps
    // at once instead of running all the way around the counter.
    assign strobe = (count_q >= sample_div);

    always_comb begin
        count_d = count_q + DIV_WIDTH'(1);
        if (clear || strobe) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/trace_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : trace_capture_ctrl
// Description : Triggered multi-channel trace capture with a vblank-aligned
//               hand-off to a double-buffered display frame.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_capture_ctrl
    import trace_capture_ctrl_pkg::*;
#(
    parameter int DATA_SIZE = c_DEFAULT_DATA_SIZE,
    parameter int CHANNELS  = c_DEFAULT_CHANNELS,
    parameter int DIV_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CHANNELS-1:0]           ch_in,
    input  logic                          arm,
    input  logic                          abort,
    input  logic [$clog2(CHANNELS)-1:0]   trig_ch,
    input  logic                          trig_rise,
    input  logic [DIV_WIDTH-1:0]          sample_div,
    input  logic                          vblank,
    output logic [CHANNELS*DATA_SIZE-1:0] data_out,
    output logic                          busy,
    output logic                          frame_done
);

    localparam int                IDX_W      = $clog2(DATA_SIZE);
    localparam logic [IDX_W-1:0]  c_LAST_IDX = IDX_W'(DATA_SIZE - 1);

    state_t                        state_q, state_d;
    logic [CHANNELS-1:0]           sync1_q, sync2_q;
    logic                          vblank_q;
    logic                          prev_q, prev_d;
    logic                          prev_vld_q, prev_vld_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [CHANNELS*DATA_SIZE-1:0] data_out_q;
    logic                          frame_done_q;
    logic [CHANNELS*DATA_SIZE-1:0] cap_w;
    logic                          wr_en_w;
    logic [IDX_W-1:0]              wr_idx_w;
    logic                          xfer_w;
    logic                          strobe_w;
    logic                          div_clear_w;
    logic                          trig_smp_w;

    sample_strobe_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_strobe (
        .clk        (clk),
        .reset      (reset),
        .clear      (div_clear_w),
        .sample_div (sample_div),
        .strobe     (strobe_w)
    );

    assign trig_smp_w  = sync2_q[trig_ch];
    assign div_clear_w = (state_q != ST_ARMED) && (state_d == ST_ARMED);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        wr_en_w    = 1'b0;
        wr_idx_w   = idx_q;
        xfer_w     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d    = ST_ARMED;
                    prev_vld_d = 1'b0;
                end
            end
            ST_ARMED: begin
                if (strobe_w) begin
                    prev_d     = trig_smp_w;
                    prev_vld_d = 1'b1;
                    if (prev_vld_q && (trig_rise ? (!prev_q && trig_smp_w)
                                                 : (prev_q && !trig_smp_w))) begin
                        state_d  = ST_CAPTURE;
                        wr_en_w  = 1'b1;
                        wr_idx_w = '0;
                        idx_d    = IDX_W'(1);
                    end
                end
            end
            ST_CAPTURE: begin
                if (strobe_w) begin
                    wr_en_w = 1'b1;
                    if (idx_q == c_LAST_IDX) begin
                        state_d = ST_PENDING;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_PENDING: begin
                if (vblank && !vblank_q) begin
                    xfer_w  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
            wr_en_w = 1'b0;
            xfer_w  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sync1_q      <= '0;
            sync2_q      <= '0;
            vblank_q     <= 1'b0;
            prev_q       <= 1'b0;
            prev_vld_q   <= 1'b0;
            idx_q        <= '0;
            data_out_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= ch_in;
            sync2_q      <= sync1_q;
            vblank_q     <= vblank;
            prev_q       <= prev_d;
            prev_vld_q   <= prev_vld_d;
            idx_q        <= idx_d;
            frame_done_q <= xfer_w;
            if (xfer_w) begin
                data_out_q <= cap_w;
            end
        end
    end

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            logic [DATA_SIZE-1:0] buf_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    buf_q <= '0;
                end else if (wr_en_w) begin
                    buf_q[wr_idx_w] <= sync2_q[c];
                end
            end

            assign cap_w[c*DATA_SIZE +: DATA_SIZE] = buf_q;
        end
    endgenerate

    assign data_out   = data_out_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: doc/trace_capture_ctrl.md
TRACE_CAPTURE_CTRL -- requirements
Module: trace_capture_ctrl

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 256, samples per channel trace (one display frame).
REQ-002 SHALL have parameter CHANNELS, default 4, number of captured channels.
REQ-003 SHALL have parameter DIV_WIDTH, default 16, width of the sample-rate divider.
REQ-004 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-006 SHALL have port ch_in, input, CHANNELS, raw asynchronous channel signals.
REQ-007 SHALL have port arm, input, 1, single-cycle request to start waiting for a trigger.
REQ-008 SHALL have port abort, input, 1, return to IDLE from any state.
REQ-009 SHALL have port trig_ch, input, $clog2(CHANNELS), index of the trigger channel.
REQ-010 SHALL have port trig_rise, input, 1, 1 = trigger on rising edge, 0 = falling edge.
REQ-011 SHALL have port sample_div, input, DIV_WIDTH, sample period minus one, in clk cycles.
REQ-012 SHALL have port vblank, input, 1, high during the VGA vertical blanking interval.
REQ-013 SHALL have port data_out, output, CHANNELS*DATA_SIZE, display buffer; channel c occupies bits [c*DATA_SIZE +: DATA_SIZE].
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have port frame_done, output, 1, one-cycle pulse when data_out is updated.

Function
REQ-016 ch_in SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value.
REQ-017 The divider SHALL count 0..sample_div and emit a sample strobe when the count equals sample_div, giving one strobe every sample_div+1 cycles; sample_div=0 strobes every cycle.
REQ-018 The divider SHALL clear to 0 on entry to ARMED.
REQ-019 States SHALL be IDLE, ARMED, CAPTURE and PENDING.
REQ-020 IDLE: arm=1 -> ARMED; otherwise stay.
REQ-021 ARMED: on each strobe, compare the trigger-channel sample with the previous strobe's sample; a 0->1 change (trig_rise=1) or 1->0 change (trig_rise=0) -> CAPTURE; the first strobe after entry only loads the previous-sample register and never triggers.
REQ-022 The triggering sample SHALL be stored as sample index 0 of every channel.
REQ-023 CAPTURE: each strobe SHALL store all channels at the next index; sample k of channel c goes to capture buffer bit c*DATA_SIZE+k.
REQ-024 After index DATA_SIZE-1 is stored, the state SHALL be PENDING on the next cycle.
REQ-025 PENDING: on a vblank rising edge (vblank=1, previous-cycle vblank=0), the capture buffer SHALL be copied into data_out, frame_done SHALL pulse in the same cycle, and the state SHALL be IDLE on the next cycle.
REQ-026 data_out SHALL change only in the cycle of REQ-025, so the display never sees a partial frame.
REQ-027 A vblank already high on PENDING entry SHALL NOT transfer; the next rising edge is required.
REQ-028 abort=1 SHALL force IDLE on the next cycle from any state, leaving data_out unchanged.
REQ-029 If abort and arm are both 1, abort SHALL win.
REQ-030 arm outside IDLE SHALL be ignored.
REQ-031 Changes to trig_ch, trig_rise or sample_div while busy SHALL take effect at the next strobe or comparison; no restart.

Reset
REQ-032 reset SHALL force IDLE; divider, sample index, synchronizers, previous-sample register, capture buffer and data_out SHALL all be 0; busy=0 and frame_done=0.
REQ-033 Reset mid-capture SHALL discard the partial capture.

Structure
REQ-034 A shared package SHALL hold the state enumeration, plus default DATA_SIZE and CHANNELS, which are shared with the pixel-status renderer.
REQ-035 The divider SHALL be one sub-module, sample_strobe_gen (inputs: clk, reset, clear, sample_div; output: strobe).

Verification
REQ-036 With sample_div=3, arm held in IDLE: strobe SHALL occur every 4 clk cycles.
REQ-037 Rising trigger: CHANNELS=4, DATA_SIZE=8, sample_div=0, trig_ch=2, trig_rise=1, ch_in[2] 0->1 after arm, ch_in[0] alternating -> bit 0 of channel 2 SHALL be 1 and channel 0 SHALL hold the alternating pattern starting at bit 0 after vblank.
REQ-038 Falling trigger: trig_rise=0 with a rising edge only -> SHALL stay ARMED with busy=1 and no capture.
REQ-039 vblank held high through PENDING entry, low 5 cycles, then high -> single transfer and frame_done pulse on the second rise only.
REQ-040 Abort in CAPTURE at index 3 -> IDLE next cycle; data_out SHALL keep the previous frame; a new arm-trigger cycle SHALL work normally.
REQ-041 Reset asserted in ARMED, then released -> all outputs 0 and state IDLE; arm on the same cycle as abort -> SHALL stay IDLE.
